// File: rtl/i2s_receive_24.sv
// i2s_receive_24
// Receive side of the 24-bit I2S link. SCK, WS and SD are oversampled in the
// clk_i domain, 24-bit MSB-first words are deserialised after the one-bit
// I2S delay slot, and each complete word is offered on a valid/ready stream
// tagged with the WS level it was shifted in under.
//
// Ports:
//   clk_i                 system clock (>= 4x SCK)
//   rst_i                 synchronous active-high reset
//   sck_i, ws_i, sd_i     asynchronous I2S bus (ws: 0 = left, 1 = right)
//   sample_o              received signed 24-bit word
//   channel_o             channel tag of sample_o
//   valid_o / ready_i     output stream handshake
//   short_word_o          one-cycle pulse: word ended with < 25 SCK falls
//   overrun_o             sticky: an unaccepted word was overwritten
//   err_clr_i             clears overrun_o (a simultaneous new overrun wins)
//   debug_state_receiving high while in ST_RECEIVE
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_WAIT_WS | after reset; SCK ignored until the first WS edge
// ST_RECEIVE | framing established; counting bits, left only by reset

module i2s_receive_24 #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sck_i,
  input  logic        ws_i,
  input  logic        sd_i,
  output logic [23:0] sample_o,
  output logic        channel_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        short_word_o,
  output logic        overrun_o,
  input  logic        err_clr_i,
  output logic        debug_state_receiving
);

  typedef enum logic {
    ST_WAIT_WS = 1'b0,
    ST_RECEIVE = 1'b1
  } state_t;

  // cnt_q: 0 = delay slot pending, 1..24 = data bits taken, 25 = word full
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(25);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sck_sync_q, ws_sync_q, sd_sync_q;
  logic                   sck_dly_q, ws_dly_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [23:0]            shift_q;
  logic [23:0]            sample_q;
  logic                   channel_q, valid_q, short_q, overrun_q;

  logic sck_s, ws_s, sd_s;
  logic sck_fall, ws_edge;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ws_s     = ws_sync_q[SYNC_STAGES-1];
  assign sd_s     = sd_sync_q[SYNC_STAGES-1];
  assign sck_fall = sck_dly_q & ~sck_s;
  assign ws_edge  = ws_dly_q ^ ws_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_WAIT_WS;
      sck_sync_q <= '0;
      ws_sync_q  <= '0;
      sd_sync_q  <= '0;
      sck_dly_q  <= 1'b0;
      ws_dly_q   <= 1'b0;
      cnt_q      <= '0;
      shift_q    <= '0;
      sample_q   <= '0;
      channel_q  <= 1'b0;
      valid_q    <= 1'b0;
      short_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      ws_sync_q  <= {ws_sync_q[SYNC_STAGES-2:0], ws_i};
      sd_sync_q  <= {sd_sync_q[SYNC_STAGES-2:0], sd_i};
      sck_dly_q  <= sck_s;
      ws_dly_q   <= ws_s;
      short_q    <= 1'b0;

      // Later assignments below (commit / new overrun) override these.
      if (valid_q && ready_i) valid_q <= 1'b0;
      if (err_clr_i) overrun_q <= 1'b0;

      case (state_q)
        ST_WAIT_WS: begin
          if (ws_edge) begin
            state_q <= ST_RECEIVE;
            cnt_q   <= '0;
            shift_q <= '0;
          end
        end

        ST_RECEIVE: begin
          // WS edge has priority over a coincident SCK fall.
          if (ws_edge) begin
            cnt_q   <= '0;
            shift_q <= '0;
            if (cnt_q == CNT_FULL) begin
              sample_q  <= shift_q;
              channel_q <= ws_dly_q;
              valid_q   <= 1'b1;
              if (valid_q && !ready_i) overrun_q <= 1'b1;
            end else begin
              short_q <= 1'b1;
            end
          end else if (sck_fall) begin
            if (cnt_q == '0) begin
              cnt_q <= CNT_ONE;
            end else if (cnt_q < CNT_FULL) begin
              shift_q <= {shift_q[22:0], sd_s};
              cnt_q   <= cnt_q + CNT_ONE;
            end else begin
              cnt_q <= CNT_FULL;
            end
          end
        end

        default: state_q <= ST_WAIT_WS;
      endcase
    end
  end

  assign sample_o              = sample_q;
  assign channel_o             = channel_q;
  assign valid_o               = valid_q;
  assign short_word_o          = short_q;
  assign overrun_o             = overrun_q;
  assign debug_state_receiving = (state_q == ST_RECEIVE);

endmodule

// File: tb/tb_i2s_receive_24.sv
module tb_i2s_receive_24;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        sck_i = 1'b0;
  logic        ws_i  = 1'b0;
  logic        sd_i  = 1'b0;
  logic        ready_i = 1'b1;
  logic        err_clr_i = 1'b0;
  logic [23:0] sample_o;
  logic        channel_o, valid_o, short_word_o, overrun_o, debug_state_receiving;

  i2s_receive_24 #(.SYNC_STAGES(2), .CNT_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sck_i(sck_i), .ws_i(ws_i), .sd_i(sd_i),
    .sample_o(sample_o), .channel_o(channel_o), .valid_o(valid_o),
    .ready_i(ready_i), .short_word_o(short_word_o), .overrun_o(overrun_o),
    .err_clr_i(err_clr_i), .debug_state_receiving(debug_state_receiving)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a slot is the stretch of SCK periods between two WS
  // toggles. Once any WS toggle has been seen since reset, each slot closed by
  // a later toggle yields a word (>= 25 falls) or a short-word event.
  logic [24:0] exp_q[$];
  logic [24:0] obs_q[$];
  int          exp_short, obs_short;
  bit          pend_valid;
  logic        pend_ch;
  int          pend_n;
  logic [23:0] pend_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (valid_o && ready_i) obs_q.push_back({channel_o, sample_o});
      if (short_word_o) obs_short++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic sck_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      sck_i = 1'b1; sd_i = 1'($urandom_range(0, 1));
      wait_clk(4);
      sck_i = 1'b0;
      wait_clk(4);
    end
  endtask

  // Toggles WS, then sends nsck SCK periods: delay slot, data MSB first,
  // random trailing bits.
  task automatic slot(input logic [23:0] data, input int nsck);
    if (pend_valid) begin
      if (pend_n >= 25) exp_q.push_back({pend_ch, pend_data});
      else exp_short++;
    end
    ws_i = ~ws_i;
    pend_valid = 1'b1;
    pend_ch    = ws_i;
    pend_n     = nsck;
    pend_data  = data;
    for (int i = 0; i < nsck; i++) begin
      sck_i = 1'b1;
      if (i >= 1 && i <= 24) sd_i = data[24-i];
      else sd_i = 1'($urandom_range(0, 1));
      wait_clk(4);
      sck_i = 1'b0;
      wait_clk(4);
    end
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1'b1; sck_i = 1'b0; sd_i = 1'b0; ws_i = 1'b0; err_clr_i = 1'b0;
    wait_clk(3);
    check({tag, "_rst_out"},
          {valid_o, channel_o, short_word_o, overrun_o, debug_state_receiving, sample_o}, 32'h0);
    rst_i = 1'b0;
    wait_clk(4);
    pend_valid = 1'b0;
    exp_q.delete(); obs_q.delete();
    exp_short = 0; obs_short = 0;
  endtask

  task automatic cmp_stream(input string tag);
    wait_clk(8);
    check({tag, "_nwords"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_word"}, {7'd0, obs_q[i]}, {7'd0, exp_q[i]});
    check({tag, "_nshort"}, obs_short, exp_short);
    check({tag, "_overrun"}, overrun_o, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] a;
    logic [23:0] b;
    int          len;

    // Loopback-style stream: right dummy, left A5A5A5, right 5A5A5A.
    do_reset("init");
    ready_i = 1'b1;
    check("idle_dbg", debug_state_receiving, 1'b0);
    a = 24'($urandom);
    slot(a, 32);
    check("recv_dbg", debug_state_receiving, 1'b1);
    slot(24'hA5A5A5, 32);
    slot(24'h5A5A5A, 32);
    slot(24'h0, 2);
    cmp_stream("loop");

    // Reset mid-word, SCK activity before the first WS edge is ignored.
    slot(24'hABCDEF, 14);
    do_reset("mid");
    sck_pulses(10);
    check("partial_dbg", debug_state_receiving, 1'b0);
    slot(24'h123456, 25);
    slot(24'h0, 2);
    cmp_stream("partial");

    // Short word: 12 SCK periods.
    do_reset("short");
    slot(24'hFFFFFF, 12);
    slot(24'h0, 2);
    wait_clk(8);
    check("short_valid", valid_o, 1'b0);
    cmp_stream("short");

    // Long 32-bit slots.
    do_reset("long");
    slot(24'h800001, 32);
    slot(24'h0000FF, 32);
    slot(24'h0, 2);
    cmp_stream("long");

    // Backpressure and overrun.
    do_reset("bp");
    ready_i = 1'b0;
    slot(24'h000001, 25);
    slot(24'h000002, 25);
    slot(24'h0, 2);
    check("bp_sample", sample_o, 24'h000002);
    check("bp_valid", valid_o, 1'b1);
    check("bp_overrun", overrun_o, 1'b1);
    err_clr_i = 1'b1;
    wait_clk(1);
    err_clr_i = 1'b0;
    check("bp_clr", overrun_o, 1'b0);
    check("bp_hold", sample_o, 24'h000002);
    ready_i = 1'b1;
    wait_clk(2);
    check("bp_drain", valid_o, 1'b0);

    // Handshake on the same cycle as a new commit.
    do_reset("hs");
    ready_i = 1'b0;
    a = 24'($urandom);
    b = 24'($urandom);
    slot(a, 25);
    slot(b, 25);
    check("hs_pre_sample", sample_o, a);
    fork
      slot(24'h0, 2);
      begin
        @(posedge clk_i);
        @(posedge clk_i);
        #1 ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("hs_valid", valid_o, 1'b1);
        check("hs_sample", sample_o, b);
        check("hs_channel", channel_o, 1'b0);
        check("hs_overrun", overrun_o, 1'b0);
      end
    join
    cmp_stream("hs");

    // Randomised slots, including the 24/25 fall boundary.
    do_reset("rnd");
    ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      len = (i == 0) ? 24 : (i == 1) ? 25 : $urandom_range(18, 32);
      slot(24'($urandom), len);
    end
    slot(24'h0, 2);
    cmp_stream("rnd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_receive_24.md
# i2s_receive_24

Receive side of the 24-bit I2S link: oversamples an external I2S bus (SCK, WS, SD) in the system clock domain, deserialises 24-bit MSB-first two's-complement words after the standard one-bit I2S delay, and presents each completed word with its channel tag on a valid/ready stream. It is the counterpart of `i2s_transmit_24`. It sits between the external codec/ADC pins or a loopback from the transmitter and the sample RAM/FIFO logic.

## Interface
Parameters:
- SYNC_STAGES, 2, synchroniser depth applied to sck_i, ws_i and sd_i (minimum 2)
- CNT_W, 6, width of the bit counter (must hold at least 25)

Ports:
- clk_i  input  1  system clock; must be at least 4x the SCK frequency
- rst_i  input  1  reset, synchronous, active-high
- sck_i  input  1  I2S bit clock, asynchronous
- ws_i  input  1  I2S word select, asynchronous; 0 = left, 1 = right
- sd_i  input  1  I2S serial data, asynchronous
- sample_o  output  24  received word, signed
- channel_o  output  1  channel of sample_o (the WS level during which the word was shifted in)
- valid_o  output  1  sample_o/channel_o hold a word not yet accepted
- ready_i  input  1  consumer accepts the word when valid_o && ready_i
- short_word_o  output  1  one-cycle pulse: a word ended with fewer than 25 SCK falls
- overrun_o  output  1  sticky flag: an unaccepted word was overwritten
- err_clr_i  input  1  clears overrun_o
- debug_state_receiving  output  1  high in ST_RECEIVE

## Operation
- Each of sck_i, ws_i and sd_i passes through its own SYNC_STAGES flop chain. All logic uses only the synchronised values: sck_s, ws_s and sd_s.
- Edge detection:
  - sck_fall = sck_d & ~sck_s
  - ws_edge = ws_d != ws_s
- sd_s is sampled on sck_fall, because the transmitter updates SD on the SCK rise.
- State machine:
  - ST_WAIT_WS (reset state): sck activity is ignored. The first ws_edge goes to ST_RECEIVE and produces no output.
  - ST_RECEIVE: this state persists; only reset leaves it.
- Bit counter cnt_q and shift register shift_q[23:0] in ST_RECEIVE:
  - On ws_edge: cnt_q <= 0 and shift_q <= 0. The word just finished is evaluated (see below). ws_d provides the channel of the finished word.
  - Else on sck_fall with cnt_q == 0: this is the delay slot. The bit is discarded and cnt_q <= 1.
  - Else on sck_fall with 1 <= cnt_q <= 24: shift_q <= {shift_q[22:0], sd_s} and cnt_q increments.
  - Else on sck_fall with cnt_q >= 25: the bit is ignored, so trailing bits of a 32-bit slot are dropped. cnt_q saturates at 25.
- Word evaluation on ws_edge in ST_RECEIVE:
  - cnt_q == 25: commit the word. sample_o <= shift_q, channel_o <= ws_d, valid_o <= 1.
  - cnt_q < 25: discard the word and pulse short_word_o for one cycle. The output register is untouched.
- Output handshake:
  - valid_o clears on the cycle after valid_o && ready_i, unless a commit happens in the same cycle.
  - Commit while valid_o = 1 and ready_i = 0: the new word overwrites the old one, valid_o stays 1 and overrun_o is set.
  - Commit in the same cycle as a handshake: the new word loads, valid_o stays 1 and no overrun is flagged.
  - sample_o and channel_o stay stable while valid_o = 1 and ready_i = 0, except on an overrun.
- Error clear:
  - err_clr_i clears overrun_o.
  - If err_clr_i coincides with a new overrun, set wins.

## Timing
- Reset (rst_i high at a clk_i edge) forces every output to 0: sample_o, channel_o, valid_o, short_word_o, overrun_o and debug_state_receiving.
- Reset also forces cnt_q = 0, shift_q = 0, state = ST_WAIT_WS, and all synchroniser and edge flops to 0.
- Reset mid-word drops the partial word and any pending valid word.
- Latency:
  - A pin-level WS transition reaches ws_edge after SYNC_STAGES+1 clk cycles.
  - valid_o rises on the clk edge after ws_edge.
- A ws_edge coinciding with sck_fall gives ws_edge priority; that SCK fall is not counted.
- A word with exactly 25 counted falls (delay slot plus 24 bits) is the minimum valid word.
- With back-to-back words, valid_o can stay high continuously if ready_i is held high.

## Test plan
- Loopback from `i2s_transmit_24`: send left 0xA5A5A5 then right 0x5A5A5A. Required: two valid_o beats, (0xA5A5A5, ch 0) then (0x5A5A5A, ch 1); no short_word_o.
- Post-reset partial word: release rst_i mid-frame, then send 0x123456 on the next full word. Required: the first WS edge yields no output; the next word yields 0x123456.
- Short word: drive only 12 SCK periods, then toggle WS. Required: one-cycle short_word_o pulse, valid_o stays 0.
- Long slot: send 32 SCK periods per word carrying 0x800001 then 0xFF. Required: sample_o = 0x800001 and the trailing bits are ignored.
- Backpressure: hold ready_i = 0 across two words 0x000001 and 0x000002. Required: overrun_o = 1 and sample_o = 0x000002. Pulse err_clr_i. Required: overrun_o returns to 0.
- Simultaneous handshake and commit: hold ready_i = 1 on the exact cycle a new word commits. Required: valid_o stays 1, the new word is presented, overrun_o stays 0.
